// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter
//   Shares one DRAM port between the D-cache (port 0) and I-cache (port 1)
//   line interfaces. A granted line write goes out as BURST_LEN beats of
//   DWIDTH bits, each gated by mem_ready. A granted line read goes out as one
//   request, and the returning rvalid beats are reassembled into a line.
//
//   Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, contention
//   is resolved round-robin. When it is not defined, port 0 has fixed priority.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   reqN_addr/read/write     line request, held until reqN_resp
//   reqN_wdata               write line; beat i = [DWIDTH*i +: DWIDTH]
//   reqN_rdata               last completed read line for port N
//   reqN_resp                one-cycle completion pulse
//   mem_addr/read/write      line-aligned request toward memory
//   mem_wdata                current write beat
//   mem_ready                memory accepts current read/write
//   mem_raddr/rdata/rvalid   returning read beats
module cacheline_mem_arbiter #(
  parameter int DWIDTH    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 req0_addr,
  input  logic                        req0_read,
  input  logic                        req0_write,
  input  logic [DWIDTH*BURST_LEN-1:0] req0_wdata,
  output logic [DWIDTH*BURST_LEN-1:0] req0_rdata,
  output logic                        req0_resp,
  input  logic [31:0]                 req1_addr,
  input  logic                        req1_read,
  input  logic                        req1_write,
  input  logic [DWIDTH*BURST_LEN-1:0] req1_wdata,
  output logic [DWIDTH*BURST_LEN-1:0] req1_rdata,
  output logic                        req1_resp,
  output logic [31:0]                 mem_addr,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [DWIDTH-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic [31:0]                 mem_raddr,
  input  logic [DWIDTH-1:0]           mem_rdata,
  input  logic                        mem_rvalid
);
  localparam int LW   = DWIDTH * BURST_LEN;
  localparam int OFFB = $clog2(LW / 8);
  localparam int CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [31:0]   OMASK = 32'((1 << OFFB) - 1);
  localparam logic [CW-1:0] LAST  = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RREQ, S_RDATA, S_DONE} state_t;

  state_t          state, state_nx;
  logic            gnt_q;
  logic [31:0]     addr_q;
  logic [LW-1:0]   wbuf, rbuf, line_nx;
  logic [CW-1:0]   cnt;

  logic            any_req, gnt_nx, sel_write, beat_ok;
  logic [31:0]     sel_addr;
  logic [LW-1:0]   sel_wdata;

  assign any_req = req0_read | req0_write | req1_read | req1_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Last port served; port 1 out of reset so port 0 wins the first contention.
  logic rr_last;
  always_comb begin
    if ((req0_read | req0_write) && (req1_read | req1_write)) gnt_nx = ~rr_last;
    else                                                    gnt_nx = req1_read | req1_write;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          rr_last <= 1'b1;
    else if (state == S_IDLE && any_req) rr_last <= gnt_nx;
  end
`else
  // Port 0 wins whenever it asks.
  assign gnt_nx = ~(req0_read | req0_write);
`endif

  // Read+write together on one port falls through to the write path.
  assign sel_write = gnt_nx ? req1_write : req0_write;
  assign sel_addr  = gnt_nx ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_nx ? req1_wdata : req0_wdata;

  // Beats for some other line are dropped without advancing cnt.
  assign beat_ok = mem_rvalid && (mem_raddr == addr_q);

  always_comb begin
    line_nx = rbuf;
    line_nx[cnt*DWIDTH +: DWIDTH] = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any_req) state_nx = sel_write ? S_WRITE : S_RREQ;
      S_WRITE: if (mem_ready && cnt == LAST) state_nx = S_DONE;
      S_RREQ:  if (mem_ready) state_nx = S_RDATA;
      S_RDATA: if (beat_ok && cnt == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      cnt        <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          gnt_q  <= gnt_nx;
          addr_q <= sel_addr & ~OMASK;
          wbuf   <= sel_wdata;
          cnt    <= '0;
        end
        S_WRITE: if (mem_ready) cnt <= cnt + 1'b1;
        S_RDATA: if (beat_ok) begin
          rbuf <= line_nx;
          cnt  <= cnt + 1'b1;
          // Only the completing read touches the port's rdata.
          if (cnt == LAST) begin
            if (gnt_q) req1_rdata <= line_nx;
            else       req0_rdata <= line_nx;
          end
        end
        default: ;
      endcase
    end
  end

  // Every output below is a decode of registered state.
  assign mem_addr  = addr_q;
  assign mem_write = (state == S_WRITE);
  assign mem_read  = (state == S_RREQ);
  assign mem_wdata = wbuf[cnt*DWIDTH +: DWIDTH];
  assign req0_resp = (state == S_DONE) && !gnt_q;
  assign req1_resp = (state == S_DONE) &&  gnt_q;
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
module tb_cacheline_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  req0_addr, req1_addr, mem_addr, mem_raddr;
  logic         req0_read, req0_write, req1_read, req1_write;
  logic [255:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
  logic         req0_resp, req1_resp, mem_read, mem_write, mem_ready, mem_rvalid;
  logic [63:0]  mem_wdata, mem_rdata;

  int nerr = 0;
  int nchk = 0;

  cacheline_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_addr(req0_addr), .req0_read(req0_read), .req0_write(req0_write),
    .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_addr(req1_addr), .req1_read(req1_read), .req1_write(req1_write),
    .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rbeat(input logic [31:0] a, input logic [63:0] d);
    mem_rvalid = 1'b1; mem_raddr = a; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  logic [63:0]  A, B, C, D;
  logic [255:0] line, wl;
  logic [31:0]  exp_addr;
  int           exp_port;

  initial begin
    rst = 1'b1;
    req0_addr = '0; req0_read = 0; req0_write = 0; req0_wdata = '0;
    req1_addr = '0; req1_read = 0; req1_write = 0; req1_wdata = '0;
    mem_ready = 0; mem_raddr = '0; mem_rdata = '0; mem_rvalid = 0;
    tick(); tick();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp", {req1_resp, req0_resp}, 0);
    chk("rst_rdata0", req0_rdata, 0);
    chk("rst_rdata1", req1_rdata, 0);
    rst = 1'b0;
    tick();

    // Port 0 line write, memory always ready.
    wl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    req0_addr = 32'h1000; req0_write = 1; req0_wdata = wl; mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_mem_write", mem_write, 1);
      chk("wr_mem_addr", mem_addr, 32'h1000);
      chk("wr_beat", mem_wdata, wl[64*i +: 64]);
    end
    tick();
    chk("wr_resp0", req0_resp, 1);
    chk("wr_resp1", req1_resp, 0);
    chk("wr_done_no_write", mem_write, 0);
    req0_write = 0;
    tick();
    chk("wr_resp_pulse", req0_resp, 0);

    // Port 0 write with a 10-cycle stall on beat 2; address bits [4:0] ignored.
    wl = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    req0_addr = 32'h104C; req0_write = 1; req0_wdata = wl; mem_ready = 1;
    tick(); chk("st_beat0", mem_wdata, 64'hD0);
    chk("st_addr", mem_addr, 32'h1040);
    tick(); chk("st_beat1", mem_wdata, 64'hD1);
    tick(); mem_ready = 0;
    req0_wdata = '1;   // changes after grant must not matter
    for (int k = 0; k < 10; k++) begin
      chk("st_hold_beat2", mem_wdata, 64'hD2);
      chk("st_hold_write", mem_write, 1);
      tick();
    end
    mem_ready = 1;
    chk("st_beat2", mem_wdata, 64'hD2);
    tick(); chk("st_beat3", mem_wdata, 64'hD3);
    chk("st_no_early_resp", req0_resp, 0);
    tick(); chk("st_resp", req0_resp, 1);
    req0_write = 0;
    tick();

    // Port 1 read with gapped beats and a stray beat for another line.
    A = 64'hAAAA_0000_0000_000A; B = 64'hBBBB_0000_0000_000B;
    C = 64'hCCCC_0000_0000_000C; D = 64'hDDDD_0000_0000_000D;
    req1_addr = 32'h2004; req1_read = 1; mem_ready = 1;
    tick();
    chk("rd_mem_read", mem_read, 1);
    chk("rd_mem_addr", mem_addr, 32'h2000);
    req1_addr = 32'h7000;
    tick();
    mem_ready = 0;
    chk("rd_req_dropped", mem_read, 0);
    rbeat(32'h2000, A);
    tick(); tick();
    rbeat(32'h3000, 64'hDEAD_BEEF);
    rbeat(32'h2000, B);
    tick();
    rbeat(32'h2000, C);
    rbeat(32'h3000, 64'hBAD0);
    tick(); tick();
    chk("rd_not_early", req1_resp, 0);
    rbeat(32'h2000, D);
    chk("rd_resp1", req1_resp, 1);
    chk("rd_resp0", req0_resp, 0);
    chk("rd_line", req1_rdata, {D, C, B, A});
    chk("rd_port0_untouched", req0_rdata, 0);
    req1_read = 0;
    tick();
    chk("rd_resp_pulse", req1_resp, 0);
    rbeat(32'h2000, 64'h5555);   // outside READ_DATA: ignored
    chk("rd_line_stable", req1_rdata, {D, C, B, A});

    // Both ports read continuously.
    req0_addr = 32'h4000; req1_addr = 32'h5000;
    req0_read = 1; req1_read = 1; mem_ready = 1;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_port = t % 2;
`else
      exp_port = 0;
`endif
      exp_addr = (exp_port == 0) ? 32'h4000 : 32'h5000;
      tick();
      chk("arb_mem_addr", mem_addr, exp_addr);
      chk("arb_mem_read", mem_read, 1);
      tick();
      for (int j = 0; j < 4; j++) begin
        line[64*j +: 64] = 64'(t * 16 + j + 1);
        rbeat(exp_addr, 64'(t * 16 + j + 1));
      end
      chk("arb_resp", {req1_resp, req0_resp}, (exp_port == 0) ? 2'b01 : 2'b10);
      chk("arb_line", (exp_port == 0) ? req0_rdata : req1_rdata, line);
      if (t == 3) begin req0_read = 0; req1_read = 0; end
      tick();
    end

    // Reset during READ_DATA after two beats, then retry.
    req0_addr = 32'h6000; req0_read = 1;
    tick(); chk("rr_mem_read", mem_read, 1);
    tick();
    rbeat(32'h6000, 64'h61);
    rbeat(32'h6000, 64'h62);
    rst = 1;
    #1;
    chk("rr_mem_read0", mem_read, 0);
    chk("rr_mem_addr0", mem_addr, 0);
    chk("rr_resp0", {req1_resp, req0_resp}, 0);
    chk("rr_rdata0", req0_rdata, 0);
    chk("rr_rdata1", req1_rdata, 0);
    tick();
    chk("rr_held_resp", req0_resp, 0);
    rst = 0;
    tick(); chk("rr_retry_read", mem_read, 1);
    chk("rr_retry_addr", mem_addr, 32'h6000);
    tick();
    rbeat(32'h6000, 64'h71);
    rbeat(32'h6000, 64'h72);
    rbeat(32'h6000, 64'h73);
    rbeat(32'h6000, 64'h74);
    chk("rr_retry_resp", req0_resp, 1);
    chk("rr_retry_line", req0_rdata, {64'h74, 64'h73, 64'h72, 64'h71});
    req0_read = 0;
    tick();
    chk("rr_retry_pulse", req0_resp, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/cacheline_mem_arbiter.md
# cacheline_mem_arbiter

Two-requester arbiter and burst sequencer that shares one banked DRAM port between the instruction-cache and data-cache line interfaces. Each requester issues whole 256-bit cache-line reads or writes. The arbiter grants one requester at a time and splits a write into four 64-bit beats gated by `mem_ready`. It issues each read as a single request and reassembles the four returned `rvalid` beats into a line. It sits between the two cache miss paths and the banked memory model/controller.

## Interface
Parameters:
- `DWIDTH`, 64, memory beat width in bits.
- `BURST_LEN`, 4, beats per cache line; line width is `DWIDTH*BURST_LEN` = 256.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_addr`  in  32  port 0 (D-cache) byte address; bits [4:0] ignored.
- `req0_read`  in  1  port 0 line read request; held until `req0_resp`.
- `req0_write`  in  1  port 0 line write request; held until `req0_resp`.
- `req0_wdata`  in  256  port 0 write line; beat i = [64*i +: 64].
- `req0_rdata`  out  256  port 0 read line; valid when `req0_resp`=1 after a read.
- `req0_resp`  out  1  port 0 one-cycle completion pulse.
- `req1_addr` / `req1_read` / `req1_write` / `req1_wdata` / `req1_rdata` / `req1_resp`: same widths and meaning as port 0, for port 1 (I-cache).
- `mem_addr`  out  32  line-aligned address `{addr[31:5],5'b0}`.
- `mem_read`  out  1  read request, held until `mem_ready`.
- `mem_write`  out  1  write beat valid, held until `mem_ready`.
- `mem_wdata`  out  64  current write beat.
- `mem_ready`  in  1  memory accepts the current read/write this cycle.
- `mem_raddr`  in  32  line address of the returning read beat.
- `mem_rdata`  in  64  returning read beat.
- `mem_rvalid`  in  1  read beat valid.

## Operation
- States: IDLE, WRITE, READ_REQ, READ_DATA, DONE.
- IDLE:
  - Selects a requester with `read|write` asserted.
  - Latches the grant, line address, op, and `wdata`; zeroes the beat counter.
  - Goes to WRITE if the granted port has `write`=1, else READ_REQ.
  - Both `read` and `write` asserted on one port is illegal; it is treated as a write.
- WRITE:
  - `mem_write`=1, `mem_wdata` = latched beat[cnt].
  - Each `mem_ready`=1 increments cnt.
  - Ready on beat `BURST_LEN-1` → DONE.
- READ_REQ: `mem_read`=1; `mem_ready`=1 → READ_DATA.
- READ_DATA:
  - Each `mem_rvalid`=1 with `mem_raddr` equal to the latched line address stores `mem_rdata` into line beat[cnt] and increments cnt.
  - The store of beat `BURST_LEN-1` → DONE.
  - Beats with a mismatched `raddr` are dropped and do not advance cnt.
- DONE:
  - `resp` pulses for one cycle on the granted port only.
  - The granted port's `rdata` holds the assembled line; it stays stable until that port's next read completes.
  - Next state is IDLE.
- `mem_rvalid` outside READ_DATA is ignored.
- Requesters drop `read`/`write` on the edge where they sample `resp`=1, so IDLE never re-grants a completed request.
- Inputs `req*_addr`/`wdata` may change after grant without effect.

## Timing
- Reset: all outputs 0 (`mem_*`, `req*_resp`, `req*_rdata`), state IDLE, cnt 0, round-robin pointer = port 1 (port 0 wins first).
- Reset asserted mid-burst aborts immediately; no `resp` is issued and the request must be retried.
- All outputs are driven from registered state (Moore); no input-to-output combinational path.
- The grant decision is made in the IDLE cycle; `mem_read`/`mem_write` rise the next cycle.
- Write with `mem_ready` always 1: request seen cycle 0, beats cycles 1–4, `resp` cycle 5.
- Read: `mem_read` in cycle 1; the memory returns its first `rvalid` no earlier than the cycle after the accept. `resp` comes the cycle after the last beat.
- Back-to-back: after DONE, the earliest next grant is the following IDLE cycle.
- `mem_ready` low stalls indefinitely with outputs held stable.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Round-robin. When both ports request in IDLE, the port not served last wins; the pointer updates on each grant.
  - A single requester always wins.
- Not defined:
  - Fixed priority; port 0 always wins contention.
  - The pointer register is not built.

## Test plan
- Port 0 writes line `0x1000` with beats `0x11..11`–`0x44..44` and `mem_ready` always 1 → four `mem_write` beats in order with `mem_addr`=`0x1000`; `req0_resp` at cycle 5; `req1_resp` stays 0.
- Port 1 reads `0x2004` while memory returns four beats `A,B,C,D` with `raddr`=`0x2000` and gaps of 0–3 cycles → `mem_addr`=`0x2000`; `req1_rdata`={D,C,B,A}; one-cycle `req1_resp`.
- Stray `rvalid` with `raddr`=`0x3000` interleaved during the `0x2000` read → dropped; the line is still {D,C,B,A}.
- Both ports continuously request reads:
  - With `ARB_ROUND_ROBIN_EN`, grants alternate 0,1,0,1.
  - Without it, port 0 is served repeatedly while port 1 waits.
- `mem_ready` held low for 10 cycles on write beat 2 → `mem_wdata` holds beat 2; completion is delayed by 10 cycles.
- Reset asserted during READ_DATA after 2 beats → outputs are 0 immediately; no `resp`; the reissued request completes normally.
